// File: rtl/obj_line_scan_if.sv
// Draw-command channel from the scanline object evaluator to the tile fetch/render stage.
interface obj_line_scan_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_code;
    logic [3:0]  cmd_row;
    logic [9:0]  cmd_x;
    logic [6:0]  cmd_color;
    logic        cmd_flipx;
    logic [2:0]  cmd_layer;

    modport master (
        output cmd_valid, cmd_code, cmd_row, cmd_x, cmd_color, cmd_flipx, cmd_layer,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_code, cmd_row, cmd_x, cmd_color, cmd_flipx, cmd_layer,
        output cmd_ready
    );
endinterface

// File: rtl/obj_line_scan.sv
// Walks the 256-entry object table each line and emits one draw command per object covering it.
// Latency: miss entry 3 ce, hit entry 6 ce + PUSH; empty table 768 ce from line_start to done.
// Backpressure: PUSH holds cmd_* stable and issues no further RAM address until the transfer.
module obj_line_scan #(
    parameter int MAX_OBJS = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   line_start,
    input  logic [8:0]             line,
    output logic [9:0]             obj_addr,
    input  logic [15:0]            obj_din,
    obj_line_scan_if.master        cmd,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam logic [8:0] MAX_HITS = 9'(MAX_OBJS);

    typedef enum logic [2:0] {
        IDLE, FETCH_Y, TEST, FETCH_CODE, FETCH_ATTR, FETCH_X, PUSH, NEXT
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  line_q, line_d;
    logic [7:0]  entry_q, entry_d;
    logic [8:0]  hits_q, hits_d;
    logic [9:0]  addr_q, addr_d;
    logic [8:0]  dy_q, dy_d;
    logic [1:0]  height_q, height_d;
    logic [2:0]  layer_q, layer_d;
    logic [15:0] code_q, code_d;
    logic [6:0]  color_q, color_d;
    logic        flipx_q, flipx_d;
    logic        flipy_q, flipy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic        cvld_q, cvld_d;
    logic [15:0] ccode_q, ccode_d;
    logic [3:0]  crow_q, crow_d;
    logic [9:0]  cx_q, cx_d;
    logic [6:0]  ccolor_q, ccolor_d;
    logic        cflipx_q, cflipx_d;
    logic [2:0]  clayer_q, clayer_d;

    // Hit test on w0 while it sits on obj_din; dy wraps at 512 so objects crossing line 511 work.
    logic [8:0] dy_now, span_now, span_lat, row;
    logic       hit_now;

    assign dy_now   = line_q - obj_din[8:0];
    assign span_now = 9'd16 << obj_din[10:9];
    assign hit_now  = (obj_din != 16'h0000) && (dy_now < span_now);
    assign span_lat = 9'd16 << height_q;
    assign row      = flipy_q ? (span_lat - 9'd1 - dy_q) : dy_q;

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        entry_d  = entry_q;
        hits_d   = hits_q;
        addr_d   = addr_q;
        dy_d     = dy_q;
        height_d = height_q;
        layer_d  = layer_q;
        code_d   = code_q;
        color_d  = color_q;
        flipx_d  = flipx_q;
        flipy_d  = flipy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        cvld_d   = cvld_q;
        ccode_d  = ccode_q;
        crow_d   = crow_q;
        cx_d     = cx_q;
        ccolor_d = ccolor_q;
        cflipx_d = cflipx_q;
        clayer_d = clayer_q;

        case (state_q)
            IDLE: ;
            FETCH_Y: state_d = TEST;
            TEST: begin
                if (hit_now) begin
                    dy_d     = dy_now;
                    height_d = obj_din[10:9];
                    layer_d  = obj_din[15:13];
                    addr_d   = {entry_q, 2'd1};
                    state_d  = FETCH_CODE;
                end else begin
                    state_d = NEXT;
                end
            end
            FETCH_CODE: begin
                code_d  = obj_din;
                addr_d  = {entry_q, 2'd2};
                state_d = FETCH_ATTR;
            end
            FETCH_ATTR: begin
                color_d = obj_din[6:0];
                flipx_d = obj_din[8];
                flipy_d = obj_din[9];
                addr_d  = {entry_q, 2'd3};
                state_d = FETCH_X;
            end
            FETCH_X: begin
                ccode_d  = code_q + {11'd0, row[8:4]};
                crow_d   = row[3:0];
                cx_d     = obj_din[9:0];
                ccolor_d = color_q;
                cflipx_d = flipx_q;
                clayer_d = layer_q;
                cvld_d   = 1'b1;
                state_d  = PUSH;
            end
            PUSH: begin
                if (cmd.cmd_ready) begin
                    cvld_d  = 1'b0;
                    hits_d  = hits_q + 9'd1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                // Last entry wins over the limit: a full line ending at entry 255 is not an overflow.
                if (entry_q == 8'hFF) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (hits_q == MAX_HITS) begin
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    entry_d = entry_q + 8'd1;
                    addr_d  = {entry_q + 8'd1, 2'd0};
                    state_d = FETCH_Y;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new line always restarts from entry 0, discarding any pending command silently.
        if (line_start) begin
            state_d = FETCH_Y;
            line_d  = line;
            entry_d = 8'd0;
            hits_d  = 9'd0;
            addr_d  = 10'd0;
            ovf_d   = 1'b0;
            cvld_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            line_q   <= '0;
            entry_q  <= '0;
            hits_q   <= '0;
            addr_q   <= '0;
            dy_q     <= '0;
            height_q <= '0;
            layer_q  <= '0;
            code_q   <= '0;
            color_q  <= '0;
            flipx_q  <= 1'b0;
            flipy_q  <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cvld_q   <= 1'b0;
            ccode_q  <= '0;
            crow_q   <= '0;
            cx_q     <= '0;
            ccolor_q <= '0;
            cflipx_q <= 1'b0;
            clayer_q <= '0;
        end else if (ce) begin
            state_q  <= state_d;
            line_q   <= line_d;
            entry_q  <= entry_d;
            hits_q   <= hits_d;
            addr_q   <= addr_d;
            dy_q     <= dy_d;
            height_q <= height_d;
            layer_q  <= layer_d;
            code_q   <= code_d;
            color_q  <= color_d;
            flipx_q  <= flipx_d;
            flipy_q  <= flipy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            cvld_q   <= cvld_d;
            ccode_q  <= ccode_d;
            crow_q   <= crow_d;
            cx_q     <= cx_d;
            ccolor_q <= ccolor_d;
            cflipx_q <= cflipx_d;
            clayer_q <= clayer_d;
        end
    end

    assign obj_addr      = addr_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign cmd.cmd_valid = cvld_q;
    assign cmd.cmd_code  = ccode_q;
    assign cmd.cmd_row   = crow_q;
    assign cmd.cmd_x     = cx_q;
    assign cmd.cmd_color = ccolor_q;
    assign cmd.cmd_flipx = cflipx_q;
    assign cmd.cmd_layer = clayer_q;

endmodule
